fft_input_loader: RTL and testbench
===================================

# fft_input_loader

Input stage in front of the radix-4 FFT controller. Accepts a 2048-point complex sample stream over a valid/ready handshake and writes it in natural order into RAM set A, four 512-word banks. It then pulses the controller's start input and holds off the next frame until the controller reports ready again. Sample n goes to bank n[10:9], address n[8:0], which matches the controller's first-stage read layout.

## Interface
- DATA_W, 16: width of each real/imag component.
- iCLK  in  1  clock; all logic on rising edge.
- iRESET  in  1  synchronous, active-low reset.
- iVALID  in  1  input sample valid.
- iSOP  in  1  start of frame; qualified by iVALID.
- iDATA_RE  in  DATA_W  sample real part.
- iDATA_IM  in  DATA_W  sample imaginary part.
- oREADY  out  1  loader accepts a sample this cycle.
- oWE_BANK  out  4  one-hot write enable for bank 0..3 of RAM set A.
- oADDR_WR  out  9  write address within the bank.
- oDATA_RE  out  DATA_W  registered write data, real part.
- oDATA_IM  out  DATA_W  registered write data, imaginary part.
- oSTART  out  1  one-cycle start pulse to the FFT controller.
- iFFT_RDY  in  1  controller ready/idle flag; high when no transform is running.
- oBUSY  out  1  high whenever the state is not IDLE.
- oSOP_ERR  out  1  one-cycle pulse on a framing violation.

## Operation
- A sample is accepted when iVALID & oREADY.
- The sample counter cnt is 11 bits, 0..2047.
- States and transitions:
  - IDLE: oREADY = iFFT_RDY. An accepted sample with iSOP=1 is written as n=0; cnt←1; go to LOAD. An accepted sample with iSOP=0 is discarded (no write) and pulses oSOP_ERR.
  - LOAD: oREADY=1. An accepted sample with iSOP=0 is written as n=cnt; cnt←cnt+1. An accepted sample with iSOP=1 is a restart: it is written as n=0, cnt←1, and oSOP_ERR pulses; data already written is simply overwritten later. Accepting the sample with cnt=2047 moves to FLUSH.
  - FLUSH: oREADY=0. One cycle, which lets the last write retire. Go to KICK.
  - KICK: oREADY=0, oSTART=1 for exactly one cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: oREADY=0. When iFFT_RDY=0, go to WAIT_DONE.
  - WAIT_DONE: oREADY=0. When iFFT_RDY=1, go to IDLE.
- Write port, registered, updated every cycle:
  - oWE_BANK = accepted-and-written ? (4'b0001 << n[10:9]) : 0.
  - oADDR_WR = n[8:0].
  - oDATA_RE/oDATA_IM capture the accepted data.
  - When no write occurs, address and data hold their previous values.
- cnt wraps only by a state change; it never exceeds 2047.
- oBUSY = (state != IDLE).

## Timing
- Reset (iRESET=0 at a clock edge) puts the state in IDLE and cnt at 0. Output values after reset:
  - oREADY follows iFFT_RDY.
  - oWE_BANK=0, oADDR_WR=0, oDATA_RE=0, oDATA_IM=0.
  - oSTART=0, oBUSY=0, oSOP_ERR=0.
- Reset mid-frame abandons the frame. No start is issued, and bank contents are not cleared.
- Write latency: a sample accepted at edge t appears on oWE_BANK/oADDR_WR/oDATA_* during cycle t+1.
- Last sample accepted at edge t:
  - last write in cycle t+1 (FLUSH);
  - oSTART high in cycle t+2 (KICK);
  - oREADY low from cycle t+1 until the cycle after iFFT_RDY rises in WAIT_DONE.
- The controller drops its ready flag the cycle after start. WAIT_BUSY therefore has no timeout; iFFT_RDY must fall.
- Best-case throughput is one sample per clock, giving 2048 cycles of load per frame.
- iSOP together with iVALID=0 is ignored.
- If iFFT_RDY=0 while in IDLE, oREADY=0 and no samples are taken.

## Test plan
- Reset then 2048 back-to-back samples, sample n = (re=n, im=-n), iSOP on n=0, iFFT_RDY=1:
  - n=0 → bank0/addr0; n=511 → bank0/addr511; n=512 → bank1/addr0; n=2047 → bank3/addr511;
  - exactly 2048 writes, each with one-hot oWE_BANK;
  - oSTART is a single pulse 2 cycles after the last acceptance.
- Random iVALID gaps (about 30% idle) → write sequence identical to the previous test; no write in any cycle without an acceptance in the previous cycle.
- Back-pressure: model the controller with iFFT_RDY falling 1 cycle after oSTART and rising 500 cycles later → oREADY=0 throughout that period; the next frame is accepted starting the cycle after iFFT_RDY rises.
- Framing errors:
  - 3 samples without iSOP in IDLE → 3 oSOP_ERR pulses, zero writes.
  - iSOP at n=100 mid-frame → oSOP_ERR pulse, that sample is written to bank0/addr0, and oSTART only after 2048 further samples.
- Reset asserted at n=1000 → all outputs return to their reset values the next cycle, no oSTART, and the next iSOP frame loads correctly.

Source files
------------

// File: rtl/fft_input_loader.sv
// fft_input_loader: loads a 2048-point sample frame into 4x512 RAM banks, kicks the FFT and waits for completion; ports: iCLK/iRESET(sync, low), iVALID/iSOP/iDATA_* in, oREADY, oWE_BANK/oADDR_WR/oDATA_* write port, oSTART/iFFT_RDY to controller, oBUSY, oSOP_ERR
module fft_input_loader #(
  parameter int DATA_W = 16
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iVALID,
  input  logic              iSOP,
  input  logic [DATA_W-1:0] iDATA_RE,
  input  logic [DATA_W-1:0] iDATA_IM,
  output logic              oREADY,
  output logic [3:0]        oWE_BANK,
  output logic [8:0]        oADDR_WR,
  output logic [DATA_W-1:0] oDATA_RE,
  output logic [DATA_W-1:0] oDATA_IM,
  output logic              oSTART,
  input  logic              iFFT_RDY,
  output logic              oBUSY,
  output logic              oSOP_ERR
);
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, KICK, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [10:0] cnt, cnt_n, n;
  logic acc, wr, err;
  assign oREADY = state == IDLE ? iFFT_RDY : state == LOAD;
  assign acc = iVALID & oREADY;
  assign wr = acc & (iSOP | state == LOAD);
  assign n = iSOP ? 11'd0 : cnt;
  assign err = acc & (state == IDLE ? !iSOP : iSOP);
  assign oSTART = state == KICK;
  assign oBUSY = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (acc & iSOP) begin
        state_n = LOAD;
        cnt_n = 11'd1;
      end
      LOAD: if (acc) begin
        cnt_n = iSOP ? 11'd1 : cnt + 11'd1;
        state_n = !iSOP && cnt == 11'd2047 ? FLUSH : LOAD;
      end
      FLUSH: state_n = KICK;
      KICK: state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = iFFT_RDY ? WAIT_BUSY : WAIT_DONE;
      WAIT_DONE: state_n = iFFT_RDY ? IDLE : WAIT_DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state <= IDLE;
      cnt <= '0;
      oWE_BANK <= '0;
      oADDR_WR <= '0;
      oDATA_RE <= '0;
      oDATA_IM <= '0;
      oSOP_ERR <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      oWE_BANK <= wr ? 4'b0001 << n[10:9] : 4'b0000;
      oSOP_ERR <= err;
      if (wr) begin
        oADDR_WR <= n[8:0];
        oDATA_RE <= iDATA_RE;
        oDATA_IM <= iDATA_IM;
      end
    end
  end
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: directed self-checking bench for fft_input_loader
module tb_fft_input_loader;
  localparam int W = 16;
  logic iCLK = 1'b0, iRESET = 1'b0, iVALID = 1'b0, iSOP = 1'b0, iFFT_RDY = 1'b1;
  logic [W-1:0] iDATA_RE = '0, iDATA_IM = '0;
  logic oREADY, oSTART, oBUSY, oSOP_ERR;
  logic [3:0] oWE_BANK;
  logic [8:0] oADDR_WR;
  logic [W-1:0] oDATA_RE, oDATA_IM;
  int errors = 0, checks = 0;
  int cyc_n = 0, wr_cnt = 0, bad_hot = 0, spurious = 0, starts = 0, sop_errs = 0, start_cyc = 0, last_acc = 0;
  logic acc_q = 1'b0;
  logic [10:0] log_n [16384];
  logic [W-1:0] log_re [16384];
  logic [W-1:0] log_im [16384];

  fft_input_loader #(.DATA_W(W)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .iSOP(iSOP),
    .iDATA_RE(iDATA_RE), .iDATA_IM(iDATA_IM), .oREADY(oREADY),
    .oWE_BANK(oWE_BANK), .oADDR_WR(oADDR_WR), .oDATA_RE(oDATA_RE),
    .oDATA_IM(oDATA_IM), .oSTART(oSTART), .iFFT_RDY(iFFT_RDY),
    .oBUSY(oBUSY), .oSOP_ERR(oSOP_ERR)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [1:0] bank_of(input logic [3:0] w);
    return w[3] ? 2'd3 : w[2] ? 2'd2 : w[1] ? 2'd1 : 2'd0;
  endfunction

  always @(negedge iCLK) begin
    cyc_n++;
    if (oWE_BANK != 4'd0) begin
      if (wr_cnt < 16384) begin
        log_n[wr_cnt] = {bank_of(oWE_BANK), oADDR_WR};
        log_re[wr_cnt] = oDATA_RE;
        log_im[wr_cnt] = oDATA_IM;
      end
      wr_cnt++;
      if (!$onehot(oWE_BANK)) bad_hot++;
      if (!acc_q) spurious++;
    end
    if (oSTART) begin
      starts++;
      start_cyc = cyc_n;
    end
    if (oSOP_ERR) sop_errs++;
    acc_q = iVALID & oREADY & iRESET;
    if (acc_q) last_acc = cyc_n;
  end

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic send(input logic sop, input int n);
    bit ok = 1'b0;
    iVALID = 1'b1;
    iSOP = sop;
    iDATA_RE = W'(n);
    iDATA_IM = W'(-n);
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge iCLK);
      ok = oREADY;
      cyc();
    end
    iVALID = 1'b0;
    iSOP = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout n=%0d: oREADY stayed 0, required 1", n);
    end
  endtask

  task automatic load_frame(input bit gaps, input int first, input int count, input bit sop0);
    for (int k = 0; k < count; k++) begin
      if (gaps && $urandom_range(0, 9) < 3) cyc();
      send(sop0 && k == 0, first + k);
    end
  endtask

  task automatic fft_run(input int len, output int hi);
    bit seen = 1'b0;
    hi = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge iCLK);
      seen = oSTART;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: oSTART=0, required 1");
    end
    cyc();
    iFFT_RDY = 1'b0;
    repeat (len) begin
      @(negedge iCLK);
      if (oREADY) hi++;
      cyc();
    end
    iFFT_RDY = 1'b1;
  endtask

  task automatic do_reset();
    iRESET = 1'b0;
    iVALID = 1'b0;
    iSOP = 1'b0;
    iFFT_RDY = 1'b1;
    cyc();
    cyc();
    iRESET = 1'b1;
  endtask

  task automatic test_reset();
    int w0;
    iRESET = 1'b0;
    iVALID = 1'b1;
    iSOP = 1'b1;
    iDATA_RE = 16'h1234;
    iFFT_RDY = 1'b1;
    cyc();
    cyc();
    @(negedge iCLK);
    checks++; if (oREADY !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", oREADY); end
    checks++; if (oWE_BANK !== 4'd0) begin errors++; $display("FAIL rst_we: got %b required 0000", oWE_BANK); end
    checks++; if (oADDR_WR !== 9'd0) begin errors++; $display("FAIL rst_addr: got %0d required 0", oADDR_WR); end
    checks++; if (oDATA_RE !== '0 || oDATA_IM !== '0) begin errors++; $display("FAIL rst_data: got %h/%h required 0/0", oDATA_RE, oDATA_IM); end
    checks++; if ({oSTART, oBUSY, oSOP_ERR} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b required 000", {oSTART, oBUSY, oSOP_ERR}); end
    iFFT_RDY = 1'b0;
    #1;
    checks++; if (oREADY !== 1'b0) begin errors++; $display("FAIL rst_ready_follow: got %b required 0", oREADY); end
    cyc();
    w0 = wr_cnt;
    iRESET = 1'b1;
    repeat (4) cyc();
    checks++; if (wr_cnt - w0 !== 0 || oBUSY !== 1'b0) begin errors++; $display("FAIL idle_not_ready: writes=%0d busy=%b required 0/0", wr_cnt - w0, oBUSY); end
    iVALID = 1'b0;
    iSOP = 1'b0;
    iFFT_RDY = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back();
    int w0, c0, bad, hi;
    w0 = wr_cnt;
    c0 = cyc_n;
    load_frame(1'b0, 0, 2048, 1'b1);
    checks++; if (cyc_n - c0 !== 2048) begin errors++; $display("FAIL b2b_cycles: got %0d required 2048", cyc_n - c0); end
    @(negedge iCLK);
    checks++; if (oREADY !== 1'b0 || oBUSY !== 1'b1) begin errors++; $display("FAIL b2b_flush: ready=%b busy=%b required 0/1", oREADY, oBUSY); end
    fft_run(5, hi);
    cyc();
    cyc();
    checks++; if (wr_cnt - w0 !== 2048) begin errors++; $display("FAIL b2b_writes: got %0d required 2048", wr_cnt - w0); end
    checks++; if (bad_hot !== 0) begin errors++; $display("FAIL b2b_onehot: got %0d bad required 0", bad_hot); end
    checks++; if (log_n[w0] !== 11'd0 || log_re[w0] !== 16'd0) begin errors++; $display("FAIL b2b_n0: got %h/%h required 000/0000", log_n[w0], log_re[w0]); end
    checks++; if (log_n[w0+511] !== {2'd0, 9'd511}) begin errors++; $display("FAIL b2b_n511: got %h required 1ff", log_n[w0+511]); end
    checks++; if (log_n[w0+512] !== {2'd1, 9'd0} || log_im[w0+512] !== 16'hfe00) begin errors++; $display("FAIL b2b_n512: got %h/%h required 200/fe00", log_n[w0+512], log_im[w0+512]); end
    checks++; if (log_n[w0+2047] !== {2'd3, 9'd511} || log_re[w0+2047] !== 16'd2047) begin errors++; $display("FAIL b2b_n2047: got %h/%h required 7ff/07ff", log_n[w0+2047], log_re[w0+2047]); end
    bad = 0;
    for (int k = 0; k < 2048; k++)
      if (log_n[w0+k] !== 11'(k) || log_re[w0+k] !== W'(k) || log_im[w0+k] !== W'(-k)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_sequence: got %0d wrong writes required 0", bad); end
    checks++; if (starts !== 1 || start_cyc - last_acc !== 2) begin errors++; $display("FAIL b2b_start: starts=%0d delay=%0d required 1/2", starts, start_cyc - last_acc); end
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b required 0", oBUSY); end
  endtask

  task automatic test_gaps();
    int w0, s0, sp0, bad, hi;
    w0 = wr_cnt;
    s0 = starts;
    sp0 = spurious;
    load_frame(1'b1, 0, 2048, 1'b1);
    fft_run(3, hi);
    cyc();
    cyc();
    checks++; if (wr_cnt - w0 !== 2048) begin errors++; $display("FAIL gap_writes: got %0d required 2048", wr_cnt - w0); end
    bad = 0;
    for (int k = 0; k < 2048; k++)
      if (log_n[w0+k] !== 11'(k) || log_re[w0+k] !== W'(k) || log_im[w0+k] !== W'(-k)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL gap_sequence: got %0d wrong writes required 0", bad); end
    checks++; if (spurious - sp0 !== 0) begin errors++; $display("FAIL gap_spurious: got %0d required 0", spurious - sp0); end
    checks++; if (starts - s0 !== 1 || start_cyc - last_acc !== 2) begin errors++; $display("FAIL gap_start: starts=%0d delay=%0d required 1/2", starts - s0, start_cyc - last_acc); end
  endtask

  task automatic test_backpressure();
    int hi;
    load_frame(1'b0, 0, 2048, 1'b1);
    fft_run(500, hi);
    checks++; if (hi !== 0) begin errors++; $display("FAIL bp_ready_low: got %0d ready cycles required 0", hi); end
    @(negedge iCLK);
    checks++; if (oREADY !== 1'b0) begin errors++; $display("FAIL bp_rise_cycle: got %b required 0", oREADY); end
    cyc();
    @(negedge iCLK);
    checks++; if (oREADY !== 1'b1 || oBUSY !== 1'b0) begin errors++; $display("FAIL bp_resume: ready=%b busy=%b required 1/0", oREADY, oBUSY); end
    cyc();
    send(1'b1, 7);
    @(negedge iCLK);
    checks++; if (oWE_BANK !== 4'b0001 || oADDR_WR !== 9'd0 || oDATA_RE !== 16'd7) begin errors++; $display("FAIL bp_next_frame: we=%b addr=%0d re=%0d required 0001/0/7", oWE_BANK, oADDR_WR, oDATA_RE); end
    cyc();
    do_reset();
  endtask

  task automatic test_framing();
    int w0, e0, s0, hi;
    w0 = wr_cnt;
    e0 = sop_errs;
    repeat (3) send(1'b0, 5);
    cyc();
    cyc();
    checks++; if (sop_errs - e0 !== 3) begin errors++; $display("FAIL nosop_errs: got %0d required 3", sop_errs - e0); end
    checks++; if (wr_cnt - w0 !== 0 || oBUSY !== 1'b0) begin errors++; $display("FAIL nosop_writes: writes=%0d busy=%b required 0/0", wr_cnt - w0, oBUSY); end
    w0 = wr_cnt;
    e0 = sop_errs;
    s0 = starts;
    load_frame(1'b0, 0, 100, 1'b1);
    send(1'b1, 100);
    @(negedge iCLK);
    checks++; if (oSOP_ERR !== 1'b1 || oWE_BANK !== 4'b0001 || oADDR_WR !== 9'd0 || oDATA_RE !== 16'd100) begin errors++; $display("FAIL restart_write: err=%b we=%b addr=%0d re=%0d required 1/0001/0/100", oSOP_ERR, oWE_BANK, oADDR_WR, oDATA_RE); end
    cyc();
    load_frame(1'b0, 101, 2046, 1'b0);
    cyc();
    cyc();
    checks++; if (starts - s0 !== 0 || oREADY !== 1'b1) begin errors++; $display("FAIL restart_early: starts=%0d ready=%b required 0/1", starts - s0, oREADY); end
    send(1'b0, 2147);
    fft_run(4, hi);
    cyc();
    cyc();
    checks++; if (starts - s0 !== 1 || sop_errs - e0 !== 1) begin errors++; $display("FAIL restart_done: starts=%0d errs=%0d required 1/1", starts - s0, sop_errs - e0); end
    checks++; if (wr_cnt - w0 !== 2148 || log_n[w0+2147] !== 11'd2047 || log_re[w0+2147] !== 16'd2147) begin errors++; $display("FAIL restart_last: writes=%0d n=%0d re=%0d required 2148/2047/2147", wr_cnt - w0, log_n[w0+2147], log_re[w0+2147]); end
  endtask

  task automatic test_mid_reset();
    int w0, s0, bad, hi;
    s0 = starts;
    load_frame(1'b0, 0, 1000, 1'b1);
    iRESET = 1'b0;
    iVALID = 1'b1;
    iSOP = 1'b0;
    cyc();
    @(negedge iCLK);
    checks++; if (oWE_BANK !== 4'd0 || oADDR_WR !== 9'd0 || oDATA_RE !== '0 || oDATA_IM !== '0) begin errors++; $display("FAIL mrst_port: we=%b addr=%0d re=%h im=%h required 0/0/0/0", oWE_BANK, oADDR_WR, oDATA_RE, oDATA_IM); end
    checks++; if ({oREADY, oSTART, oBUSY, oSOP_ERR} !== 4'b1000) begin errors++; $display("FAIL mrst_flags: got %b required 1000", {oREADY, oSTART, oBUSY, oSOP_ERR}); end
    cyc();
    iVALID = 1'b0;
    iRESET = 1'b1;
    repeat (10) cyc();
    checks++; if (starts - s0 !== 0) begin errors++; $display("FAIL mrst_no_start: got %0d required 0", starts - s0); end
    w0 = wr_cnt;
    load_frame(1'b0, 0, 2048, 1'b1);
    fft_run(3, hi);
    cyc();
    cyc();
    bad = 0;
    for (int k = 0; k < 2048; k++)
      if (log_n[w0+k] !== 11'(k) || log_re[w0+k] !== W'(k) || log_im[w0+k] !== W'(-k)) bad++;
    checks++; if (bad !== 0 || wr_cnt - w0 !== 2048) begin errors++; $display("FAIL mrst_reload: wrong=%0d writes=%0d required 0/2048", bad, wr_cnt - w0); end
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL mrst_start: got %0d required 1", starts - s0); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_backpressure();
    test_framing();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
